// File: rtl/cmp_stats.sv
// Comparator statistics: counts gt/eq/lt/error flags over a window of
// N_SAMPLES accepted results and reports them with a valid/ready handshake.
module cmp_stats #(
  parameter int unsigned N_SAMPLES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       a_gt_b,
  input  logic       a_eq_b,
  input  logic       a_lt_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] gt_cnt,
  output logic [7:0] eq_cnt,
  output logic [7:0] lt_cnt,
  output logic [7:0] err_cnt,
  output logic [3:0] eq_run_max
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(N_SAMPLES - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] n_q;
  logic [7:0] gt_q;
  logic [7:0] eq_q;
  logic [7:0] lt_q;
  logic [7:0] err_q;
  logic [3:0] run_q;
  logic [3:0] max_q;
  logic [3:0] run_inc;
  logic       accept;
  logic       clear;
  logic       one_hot;
  logic       is_eq;
  logic       last;

  assign accept  = (state_q == COLLECT) && in_valid;
  assign clear   = (state_q == IDLE) && start;
  assign one_hot = $onehot({a_gt_b, a_eq_b, a_lt_b});
  assign is_eq   = one_hot && a_eq_b;
  assign last    = (n_q == LAST);
  assign run_inc = (run_q == 4'hf) ? run_q : run_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: if (accept && last) state_d = REPORT;
      REPORT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q   <= '0;
      gt_q  <= '0;
      eq_q  <= '0;
      lt_q  <= '0;
      err_q <= '0;
      run_q <= '0;
      max_q <= '0;
    end else if (clear) begin
      n_q   <= '0;
      gt_q  <= '0;
      eq_q  <= '0;
      lt_q  <= '0;
      err_q <= '0;
      run_q <= '0;
      max_q <= '0;
    end else if (accept) begin
      n_q <= n_q + 8'd1;
      if (!one_hot) begin
        err_q <= err_q + 8'd1;
      end else begin
        unique case (1'b1)
          a_gt_b: gt_q <= gt_q + 8'd1;
          a_eq_b: eq_q <= eq_q + 8'd1;
          a_lt_b: lt_q <= lt_q + 8'd1;
        endcase
      end
      // Only a clean eq extends the run; errors break it like gt/lt.
      if (is_eq) begin
        run_q <= run_inc;
        if (run_inc > max_q) max_q <= run_inc;
      end else begin
        run_q <= '0;
      end
    end
  end

  assign in_ready   = (state_q == COLLECT);
  assign out_valid  = (state_q == REPORT);
  assign gt_cnt     = gt_q;
  assign eq_cnt     = eq_q;
  assign lt_cnt     = lt_q;
  assign err_cnt    = err_q;
  assign eq_run_max = max_q;

endmodule

// File: tb/tb_cmp_stats.sv
// Randomized bench for cmp_stats against a queue-based window model.
// Drives and samples 1 time unit after each rising edge.
module tb_cmp_stats;

  localparam int N = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       a_gt_b = 1'b0;
  logic       a_eq_b = 1'b0;
  logic       a_lt_b = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] gt_cnt;
  logic [7:0] eq_cnt;
  logic [7:0] lt_cnt;
  logic [7:0] err_cnt;
  logic [3:0] eq_run_max;

  int checks = 0;
  int failures = 0;
  int exp_g, exp_e, exp_l, exp_r, exp_m;
  logic [2:0] seq[$];

  cmp_stats #(.N_SAMPLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt),
    .err_cnt(err_cnt), .eq_run_max(eq_run_max)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, ".gt"}, gt_cnt, exp_g);
    chk({tag, ".eq"}, eq_cnt, exp_e);
    chk({tag, ".lt"}, lt_cnt, exp_l);
    chk({tag, ".err"}, err_cnt, exp_r);
    chk({tag, ".run"}, eq_run_max, exp_m);
  endtask

  // Window summary computed directly from the list of accepted flags.
  task automatic model();
    int run;
    exp_g = 0; exp_e = 0; exp_l = 0; exp_r = 0; exp_m = 0;
    run = 0;
    foreach (seq[i]) begin
      if (int'(seq[i][2]) + int'(seq[i][1]) + int'(seq[i][0]) != 1) begin
        exp_r++; run = 0;
      end else if (seq[i][2]) begin
        exp_g++; run = 0;
      end else if (seq[i][1]) begin
        exp_e++;
        run = (run < 15) ? run + 1 : 15;
        if (run > exp_m) exp_m = run;
      end else begin
        exp_l++; run = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [2:0] f);
    {a_gt_b, a_eq_b, a_lt_b} = f;
  endtask

  task automatic open_window(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".ready_open"}, in_ready, 1);
    chk({tag, ".valid_open"}, out_valid, 0);
  endtask

  task automatic feed(input string tag, input int cnt,
                      input int gap_pct, input bit noise);
    int idx = 0;
    int budget = 0;
    while (idx < cnt) begin
      if (budget++ > 400) begin
        chk({tag, ".timeout"}, idx, cnt);
        return;
      end
      chk({tag, ".ready"}, in_ready, 1);
      if (int'($urandom_range(0, 99)) >= gap_pct) begin
        in_valid = 1'b1;
        set_flags(seq[idx]);
        idx++;
      end else begin
        in_valid = 1'b0;
        set_flags(3'($urandom));
      end
      start = noise ? 1'($urandom) : 1'b0;
      tick();
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_window(input string tag, input int gap_pct,
                            input bit noise);
    int hold;
    model();
    open_window(tag);
    feed(tag, N, gap_pct, noise);
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".ready_done"}, in_ready, 0);
    chk_counts(tag);
    chk({tag, ".sum"}, gt_cnt + eq_cnt + lt_cnt + err_cnt, N);
    hold = noise ? $urandom_range(0, 5) : 5;
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid = noise ? 1'($urandom) : 1'b0;
      start = noise ? 1'($urandom) : 1'b0;
      set_flags(3'($urandom));
      tick();
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk_counts({tag, ".hold"});
    end
    in_valid = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".idle_valid"}, out_valid, 0);
    chk({tag, ".idle_ready"}, in_ready, 0);
    in_valid = 1'b1;
    set_flags(3'b010);
    tick();
    tick();
    in_valid = 1'b0;
    chk_counts({tag, ".idle"});
    chk({tag, ".idle_ready2"}, in_ready, 0);
  endtask

  function automatic logic [2:0] rand_flags();
    int r = $urandom_range(0, 9);
    if (r < 3) return 3'b100;
    if (r < 6) return 3'b010;
    if (r < 8) return 3'b001;
    return 3'($urandom);
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst.ready", in_ready, 0);
    chk("rst.valid", out_valid, 0);
    exp_g = 0; exp_e = 0; exp_l = 0; exp_r = 0; exp_m = 0;
    chk_counts("rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst.idle", in_ready, 0);

    seq = '{3'b001, 3'b100, 3'b010, 3'b100, 3'b001, 3'b010};
    run_window("mixed", 0, 1'b0);

    seq = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b010, 3'b010};
    run_window("eqrun", 40, 1'b0);
    chk("eqrun.max_const", eq_run_max, 3);

    seq = '{3'b000, 3'b100, 3'b110, 3'b010, 3'b001, 3'b010};
    run_window("errs", 20, 1'b1);
    chk("errs.err_const", err_cnt, 2);

    seq = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
    run_window("alleq", 30, 1'b1);

    // Reset mid-window discards everything.
    seq = '{3'b100, 3'b010, 3'b111};
    open_window("midrst");
    feed("midrst", 3, 0, 1'b0);
    chk("midrst.partial", gt_cnt + eq_cnt + err_cnt, 3);
    rst_n = 1'b0;
    #2;
    exp_g = 0; exp_e = 0; exp_l = 0; exp_r = 0; exp_m = 0;
    chk("midrst.ready", in_ready, 0);
    chk("midrst.valid", out_valid, 0);
    chk_counts("midrst");
    rst_n = 1'b1;
    tick();
    chk("midrst.idle", in_ready, 0);
    seq = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b011};
    run_window("fresh", 10, 1'b0);

    for (int w = 0; w < 25; w++) begin
      seq = {};
      for (int k = 0; k < N; k++) seq.push_back(rand_flags());
      run_window($sformatf("rnd%0d", w), 30, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmp_stats.md
CMP_STATS -- requirements
Module: cmp_stats

Interface
REQ-001 Parameter: N_SAMPLES, default 6, number of accepted samples per measurement window (legal range 1..255).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle request to open a new window.
REQ-006 in_valid  input  1  comparator result present this cycle.
REQ-007 in_ready  output  1  block accepts a result this cycle.
REQ-008 a_gt_b  input  1  comparator flag, a greater than b.
REQ-009 a_eq_b  input  1  comparator flag, a equal to b.
REQ-010 a_lt_b  input  1  comparator flag, a less than b.
REQ-011 out_valid  output  1  window summary available.
REQ-012 out_ready  input  1  consumer takes the summary.
REQ-013 gt_cnt  output  8  count of accepted gt samples in the window.
REQ-014 eq_cnt  output  8  count of accepted eq samples in the window.
REQ-015 lt_cnt  output  8  count of accepted lt samples in the window.
REQ-016 err_cnt  output  8  count of accepted samples whose flags are not one-hot.
REQ-017 eq_run_max  output  4  longest run of consecutive accepted eq samples, saturating at 15.

Function
REQ-018 FSM states: IDLE, COLLECT, REPORT; all outputs are registered or decoded from registered state only.
REQ-019 IDLE: in_ready=0, out_valid=0; start=1 at a rising edge clears all counters, sample count and current eq run, and moves to COLLECT.
REQ-020 COLLECT: in_ready=1; a sample is accepted at a rising edge where in_valid=1 and in_ready=1.
REQ-021 Accepted sample with exactly one flag high increments the matching counter by 1.
REQ-022 Accepted sample with zero or multiple flags high increments err_cnt only, and counts toward N_SAMPLES.
REQ-023 Accepted eq sample increments the current run and updates eq_run_max = max(eq_run_max, run) in the same edge; run and max saturate at 15.
REQ-024 Any accepted non-eq sample, including err, resets the current run to 0; cycles with in_valid=0 do not break a run.
REQ-025 The edge accepting sample number N_SAMPLES also moves to REPORT; counters include that sample; in_ready is 0 from the next cycle.
REQ-026 REPORT: out_valid=1; gt_cnt, eq_cnt, lt_cnt, err_cnt and eq_run_max are held stable while out_valid=1 and out_ready=0.
REQ-027 REPORT with out_ready=1 at a rising edge moves to IDLE; out_valid falls the next cycle.
REQ-028 Counters keep their final values in IDLE until the next accepted start.
REQ-029 start is ignored in COLLECT and REPORT; in_valid is ignored in IDLE and REPORT.
REQ-030 Invariant at REPORT: gt_cnt+eq_cnt+lt_cnt+err_cnt = N_SAMPLES; no counter can overflow.

Reset
REQ-031 rst_n low forces IDLE immediately, without waiting for a clock edge; in_ready=0, out_valid=0, all counts and eq_run_max=0, current run=0.
REQ-032 Reset asserted mid-COLLECT or mid-REPORT discards the partial window; the first cycle after release is IDLE.

Verification
REQ-033 N_SAMPLES=6, start, then flags lt,gt,eq,gt,lt,eq back-to-back -> out_valid 1 cycle after 6th accept; gt=2 eq=2 lt=2 err=0 eq_run_max=1.
REQ-034 eq,eq,(in_valid=0 x2),eq,gt,eq,eq -> eq_run_max=3, eq=5, gt=1, err=0.
REQ-035 Flags 000 then 110 among six samples -> err_cnt=2 and sum of the four counts = 6.
REQ-036 out_ready held 0 for 5 cycles in REPORT -> out_valid and all counts stable; out_ready=1 -> IDLE next cycle.
REQ-037 start pulsed in COLLECT and REPORT -> no effect; in_valid=1 in IDLE -> no count change.
REQ-038 rst_n low after 3 accepts -> outputs zero at once and state IDLE; a new start followed by 6 samples gives a correct fresh summary.
